// File: rtl/adc_acq_sequencer_pkg.sv
// Shared definitions for the ADC acquisition sequencer.
//   - field widths of the burst address/count, waveform count and gap count
//   - sequencer state encoding
//   - word tags naming the four kinds of words the write mux can emit
//   - eff_waveforms(): a waveform count of 0 is treated as a single waveform
package acq_pkg;

  localparam int BURST_W = 23;
  localparam int WFM_W   = 12;
  localparam int GAP_W   = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL_HDR,
    ST_WFM_HDR,
    ST_DATA,
    ST_GAP,
    ST_CHKSUM,
    ST_DONE
  } acq_state_e;

  localparam logic [2:0] TAG_NONE     = 3'd0;
  localparam logic [2:0] TAG_FILL_HDR = 3'd1;
  localparam logic [2:0] TAG_WFM_HDR  = 3'd2;
  localparam logic [2:0] TAG_DATA     = 3'd3;
  localparam logic [2:0] TAG_CHKSUM   = 3'd4;

  function automatic logic [WFM_W-1:0] eff_waveforms(input logic [WFM_W-1:0] n);
    return (n == '0) ? WFM_W'(1) : n;
  endfunction

endpackage

// File: rtl/adc_acq_sequencer_if.sv
// Bundle between the sequencer and the 132-bit write mux / DDR3 write FIFO.
//   master (sequencer): drives the select_* lines, checksum_update, the
//     waveform number for the header, the write strobe and its burst address;
//     receives adc_burst_valid and fifo_afull.
//   slave (mux/FIFO side): the mirror image.
interface adc_acq_sequencer_if;
  import acq_pkg::*;

  logic                select_fill_hdr;
  logic                select_waveform_hdr;
  logic                select_dat;
  logic                select_checksum;
  logic                checksum_update;
  logic [WFM_W-1:0]    current_waveform_num;
  logic [BURST_W-1:0]  ddr_burst_adr;
  logic                fifo_wr_en;
  logic                adc_burst_valid;
  logic                fifo_afull;

  modport master (
    output select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
    output checksum_update, current_waveform_num, ddr_burst_adr, fifo_wr_en,
    input  adc_burst_valid, fifo_afull
  );

  modport slave (
    input  select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
    input  checksum_update, current_waveform_num, ddr_burst_adr, fifo_wr_en,
    output adc_burst_valid, fifo_afull
  );

endinterface

// File: rtl/adc_acq_sequencer_down_cnt.sv
// Loadable down counter used for the burst and inter-waveform gap counts.
//   clk, rst_n   clock / asynchronous active-low reset
//   clr_i        synchronous clear to 0 (highest priority)
//   load_i       load load_val_i
//   dec_i        decrement by one, holding at 0
//   last_o       count is exactly 1, i.e. this decrement is the final one
module acq_down_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign last_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/adc_acq_sequencer.sv
// Per-fill sequencer for one ADC channel's acquisition datapath.
// Drives the header/data/checksum selects of the registered write mux, counts
// bursts, waveforms and gaps, and issues the FIFO write strobe aligned to the
// mux output (FIFO_LAT cycles after the select).
//   clk, rst_n                acquisition clock, asynchronous active-low reset
//   enable_i                  armed; low aborts to IDLE at the next edge
//   trig_i                    fill trigger pulse
//   num_fill_bursts_i         bursts per waveform      (latched at trigger)
//   num_waveforms_i           waveforms per fill, 0->1 (latched at trigger)
//   waveform_gap_i            idle cycles between waveforms (latched)
//   burst_start_adr_i         first DDR3 burst address (latched)
//   acq                       mux/FIFO bundle (master side)
//   busy_o                    not IDLE
//   fill_done_o               one-cycle pulse with the checksum write strobe
//   ovf_err_o, trig_missed_o  sticky error flags, cleared by a new fill start
module adc_acq_sequencer
  import acq_pkg::*;
#(
  parameter int FIFO_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic                trig_i,
  input  logic [BURST_W-1:0]  num_fill_bursts_i,
  input  logic [WFM_W-1:0]    num_waveforms_i,
  input  logic [GAP_W-1:0]    waveform_gap_i,
  input  logic [BURST_W-1:0]  burst_start_adr_i,
  adc_acq_sequencer_if.master acq,
  output logic                busy_o,
  output logic                fill_done_o,
  output logic                ovf_err_o,
  output logic                trig_missed_o
);

  acq_state_e         state_q, state_d;
  logic [BURST_W-1:0] num_bursts_q;
  logic [WFM_W-1:0]   num_wfm_q;
  logic [GAP_W-1:0]   gap_q;
  logic [BURST_W-1:0] adr_q, adr_d;
  logic [WFM_W-1:0]   wfm_q, wfm_d;
  logic               ovf_q, ovf_d;
  logic               missed_q, missed_d;

  logic start, abort, eow, more_wfm;
  logic burst_load, burst_dec, burst_last;
  logic gap_load, gap_dec, gap_last;
  logic sel_fh, sel_wh, sel_dat, sel_ck, done_pulse;
  logic [WFM_W:0] wfm_inc;

  acq_down_cnt #(.WIDTH(BURST_W)) u_burst_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (abort),
    .load_i     (burst_load),
    .load_val_i (num_bursts_q),
    .dec_i      (burst_dec),
    .last_o     (burst_last)
  );

  acq_down_cnt #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (abort),
    .load_i     (gap_load),
    .load_val_i (gap_q),
    .dec_i      (gap_dec),
    .last_o     (gap_last)
  );

  // Extra bit so wfm+1 cannot wrap when num_waveforms is at its maximum.
  assign wfm_inc  = {1'b0, wfm_q} + (WFM_W+1)'(1);
  assign more_wfm = (wfm_inc < {1'b0, num_wfm_q});

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    wfm_d      = wfm_q;
    start      = 1'b0;
    abort      = 1'b0;
    eow        = 1'b0;
    burst_load = 1'b0;
    burst_dec  = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    sel_fh     = 1'b0;
    sel_wh     = 1'b0;
    sel_dat    = 1'b0;
    sel_ck     = 1'b0;
    done_pulse = 1'b0;

    if (!enable_i) begin
      // Disarmed: nothing is selected this cycle and all counters restart.
      abort   = 1'b1;
      state_d = ST_IDLE;
      adr_d   = '0;
      wfm_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trig_i) begin
            start   = 1'b1;
            adr_d   = burst_start_adr_i;
            wfm_d   = '0;
            state_d = ST_FILL_HDR;
          end
        end
        ST_FILL_HDR: begin
          if (!acq.fifo_afull) begin
            sel_fh  = 1'b1;
            state_d = ST_WFM_HDR;
          end
        end
        ST_WFM_HDR: begin
          if (!acq.fifo_afull) begin
            sel_wh     = 1'b1;
            burst_load = 1'b1;
            if (num_bursts_q == '0) eow = 1'b1;
            else                    state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          // The ADC cannot be stalled, so fifo_afull is not looked at here.
          if (acq.adc_burst_valid) begin
            sel_dat   = 1'b1;
            burst_dec = 1'b1;
            adr_d     = adr_q + BURST_W'(1);
            if (burst_last) eow = 1'b1;
          end
        end
        ST_GAP: begin
          gap_dec = 1'b1;
          if (gap_last) state_d = ST_WFM_HDR;
        end
        ST_CHKSUM: begin
          if (!acq.fifo_afull) begin
            sel_ck  = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          done_pulse = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      // End of a waveform: either another header (after the gap) or the
      // checksum. CHKSUM is always at least one cycle after the final
      // checksum_update, giving the mux checksum time to settle.
      if (eow) begin
        if (more_wfm) begin
          wfm_d    = wfm_inc[WFM_W-1:0];
          gap_load = 1'b1;
          state_d  = (gap_q == '0) ? ST_WFM_HDR : ST_GAP;
        end else begin
          state_d  = ST_CHKSUM;
        end
      end
    end
  end

  always_comb begin
    ovf_d    = ovf_q;
    missed_d = missed_q;
    if (start) begin
      ovf_d    = 1'b0;
      missed_d = 1'b0;
    end
    if (sel_dat && acq.fifo_afull)       ovf_d    = 1'b1;
    if (trig_i && (state_q != ST_IDLE))  missed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      num_bursts_q <= '0;
      num_wfm_q    <= '0;
      gap_q        <= '0;
      adr_q        <= '0;
      wfm_q        <= '0;
      ovf_q        <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      wfm_q    <= wfm_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
      if (start) begin
        num_bursts_q <= num_fill_bursts_i;
        num_wfm_q    <= eff_waveforms(num_waveforms_i);
        gap_q        <= waveform_gap_i;
      end
    end
  end

  // Write strobe and its burst address trail the select by the mux latency.
  logic               wr_pipe_q  [FIFO_LAT];
  logic [BURST_W-1:0] adr_pipe_q [FIFO_LAT];
  logic               any_sel;

  assign any_sel = sel_fh | sel_wh | sel_dat | sel_ck;

  for (genvar gi = 0; gi < FIFO_LAT; gi++) begin : g_lat
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_pipe_q[gi]  <= 1'b0;
          adr_pipe_q[gi] <= '0;
        end else begin
          wr_pipe_q[gi]  <= any_sel;
          adr_pipe_q[gi] <= adr_q;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_pipe_q[gi]  <= 1'b0;
          adr_pipe_q[gi] <= '0;
        end else begin
          wr_pipe_q[gi]  <= wr_pipe_q[gi-1];
          adr_pipe_q[gi] <= adr_pipe_q[gi-1];
        end
      end
    end
  end

  assign acq.select_fill_hdr      = sel_fh;
  assign acq.select_waveform_hdr  = sel_wh;
  assign acq.select_dat           = sel_dat;
  assign acq.select_checksum      = sel_ck;
  assign acq.checksum_update      = sel_dat;
  assign acq.current_waveform_num = wfm_q;
  assign acq.fifo_wr_en           = wr_pipe_q[FIFO_LAT-1];
  assign acq.ddr_burst_adr        = adr_pipe_q[FIFO_LAT-1];

  assign busy_o        = (state_q != ST_IDLE);
  assign fill_done_o   = done_pulse;
  assign ovf_err_o     = ovf_q;
  assign trig_missed_o = missed_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
`timescale 1ns/1ps
module tb_adc_acq_sequencer;
  import acq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        trig = 1'b0;
  logic [22:0] nb = '0;
  logic [11:0] nw = '0;
  logic [21:0] ng = '0;
  logic [22:0] sa = '0;
  logic        busy, fill_done, ovf_err, trig_missed;

  adc_acq_sequencer_if acq();

  adc_acq_sequencer #(.FIFO_LAT(1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable_i          (enable),
    .trig_i            (trig),
    .num_fill_bursts_i (nb),
    .num_waveforms_i   (nw),
    .waveform_gap_i    (ng),
    .burst_start_adr_i (sa),
    .acq               (acq),
    .busy_o            (busy),
    .fill_done_o       (fill_done),
    .ovf_err_o         (ovf_err),
    .trig_missed_o     (trig_missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          wfm;
    logic [22:0] adr;
  } word_t;

  word_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fh_cyc, wr_cyc, done_cnt, wh_seen, last_sel_cyc, gap_exp;
  bit ovf_exp, chk_gap;
  bit pend_v = 1'b0;
  int pend_tag, pend_wfm;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pairs each write strobe with the select seen one cycle earlier
  // and compares against the next expected word of the scoreboard.
  always @(negedge clk) begin : mon
    int nsel;
    int tag;
    word_t e;
    if (!rst_n) begin
      pend_v = 1'b0;
    end else begin
      if (acq.fifo_wr_en) begin
        if (wr_cyc < 0) wr_cyc = cyc;
        chk("wr_follows_select", pend_v, 1);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("word_tag", pend_tag, e.tag);
          chk("word_adr", acq.ddr_burst_adr, e.adr);
          if (e.tag == TAG_WFM_HDR) chk("wfm_num", pend_wfm, e.wfm);
          chk("fill_done_with_ck", fill_done, e.tag == TAG_CHKSUM);
        end
      end else begin
        chk("fill_done_without_wr", fill_done, 0);
      end
      if (fill_done) done_cnt++;

      nsel = int'(acq.select_fill_hdr) + int'(acq.select_waveform_hdr) +
             int'(acq.select_dat) + int'(acq.select_checksum);
      chk("selects_onehot", nsel <= 1, 1);
      chk("checksum_update", acq.checksum_update, acq.select_dat);
      if (acq.select_fill_hdr || acq.select_waveform_hdr || acq.select_checksum)
        chk("hdr_under_afull", acq.fifo_afull, 0);
      if (acq.select_dat && acq.fifo_afull) ovf_exp = 1'b1;

      tag = TAG_NONE;
      if (acq.select_fill_hdr) begin
        tag = TAG_FILL_HDR;
        if (fh_cyc < 0) fh_cyc = cyc;
      end
      if (acq.select_waveform_hdr) begin
        tag = TAG_WFM_HDR;
        if (chk_gap && wh_seen > 0) chk("gap_idle_cycles", cyc - last_sel_cyc - 1, gap_exp);
        wh_seen++;
      end
      if (acq.select_dat)      tag = TAG_DATA;
      if (acq.select_checksum) tag = TAG_CHKSUM;
      if (nsel != 0) last_sel_cyc = cyc;
      pend_v   = (nsel != 0);
      pend_tag = tag;
      pend_wfm = int'(acq.current_waveform_num);
    end
  end

  task automatic check_all_zero(input string tagname);
    chk({tagname, "_selects"}, {acq.select_fill_hdr, acq.select_waveform_hdr, acq.select_dat,
                                acq.select_checksum, acq.checksum_update}, 0);
    chk({tagname, "_wr_en"}, acq.fifo_wr_en, 0);
    chk({tagname, "_adr"}, acq.ddr_burst_adr, 0);
    chk({tagname, "_wfm"}, acq.current_waveform_num, 0);
    chk({tagname, "_status"}, {busy, fill_done, ovf_err, trig_missed}, 0);
  endtask

  // One fill: builds the expected word list from the configuration, then
  // drives trig and per-cycle random adc_burst_valid / fifo_afull.
  // afull_hold: afull forced for cycles T+1..T+hold; afull_extra: one more cycle.
  // trig2_at: extra trig at T+n; abort_at/abort_kind: 1=reset, 2=enable low.
  task automatic run_fill(input int b, input int w, input int g, input logic [22:0] adr,
                          input int vpct, input int apct, input int afull_hold,
                          input int afull_extra, input int trig2_at, input int abort_at,
                          input int abort_kind, input bit timing);
    int wf, t0, budget;
    word_t e;
    wf = (w == 0) ? 1 : w;
    e.tag = TAG_FILL_HDR; e.wfm = 0; e.adr = adr; sb.push_back(e);
    for (int i = 0; i < wf; i++) begin
      e.tag = TAG_WFM_HDR; e.wfm = i; e.adr = 23'(adr + i * b); sb.push_back(e);
      for (int k = 0; k < b; k++) begin
        e.tag = TAG_DATA; e.adr = 23'(adr + i * b + k); sb.push_back(e);
      end
    end
    e.tag = TAG_CHKSUM; e.wfm = 0; e.adr = 23'(adr + wf * b); sb.push_back(e);
    budget = 60 + afull_hold + 10 * wf * (b + g + 2);

    nb = 23'(b); nw = 12'(w); ng = 22'(g); sa = adr;
    fh_cyc = -1; wr_cyc = -1; done_cnt = 0; ovf_exp = 1'b0; wh_seen = 0;
    chk_gap = timing; gap_exp = g;
    @(posedge clk); #1;
    trig = 1'b1;
    t0 = cyc;
    for (int n = 1; n <= budget && done_cnt == 0; n++) begin
      @(posedge clk); #1;
      trig = (n == trig2_at);
      acq.fifo_afull = (n <= afull_hold) || (n == afull_extra) || ($urandom_range(99) < apct);
      acq.adc_burst_valid = ($urandom_range(99) < vpct);
      if (n == 1) begin
        chk("busy_after_trig", busy, 1);
        chk("ovf_cleared_by_trig", ovf_err, 0);
        chk("missed_cleared_by_trig", trig_missed, 0);
      end
      if (n == abort_at) begin
        trig = 1'b0;
        if (abort_kind == 1) begin
          #2 rst_n = 1'b0;
          #1 check_all_zero("async_reset");
          acq.fifo_afull = 1'b0; acq.adc_burst_valid = 1'b0;
          sb.delete();
          repeat (2) @(posedge clk);
          #1 rst_n = 1'b1;
        end else begin
          enable = 1'b0;
          acq.fifo_afull = 1'b0; acq.adc_burst_valid = 1'b0;
          repeat (3) @(posedge clk);
          #1 chk("busy_after_disable", busy, 0);
          chk("ck_not_written_after_disable", done_cnt, 0);
          sb.delete();
          enable = 1'b1;
        end
        return;
      end
    end
    trig = 1'b0;
    acq.fifo_afull = 1'b0;
    acq.adc_burst_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fill_done_count", done_cnt, 1);
    chk("sb_drained", sb.size(), 0);
    chk("idle_after_fill", busy, 0);
    chk("ovf_err_flag", ovf_err, ovf_exp);
    chk("trig_missed_flag", trig_missed, trig2_at != 0);
    if (timing) begin
      chk("fill_hdr_latency", fh_cyc - t0, 1 + afull_hold);
      chk("first_wr_latency", wr_cyc - t0, 2 + afull_hold);
    end
    $display("fill B=%0d W=%0d gap=%0d adr=%06h done=%0d ovf=%0b missed=%0b",
             b, w, g, adr, done_cnt, ovf_err, trig_missed);
  endtask

  initial begin
    acq.adc_burst_valid = 1'b0;
    acq.fifo_afull = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;

    // trig with enable low is ignored
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
    chk("trig_without_enable", busy, 0);
    $display("trig with enable=0 -> busy=%0b", busy);
    enable = 1'b1;
    @(posedge clk); #1;

    run_fill(2, 1, 0, 23'h000100, 100, 0, 0, 0, 0, 0, 0, 1);
    run_fill(1, 3, 4, 23'h001000, 100, 0, 0, 0, 0, 0, 0, 1);
    run_fill(4, 1, 0, 23'h000020, 100, 0, 10, 13, 0, 0, 0, 1);
    run_fill(6, 1, 0, 23'h000400, 100, 0, 0, 0, 4, 0, 0, 1);
    run_fill(2, 2, 1, 23'h000800, 100, 0, 0, 0, 0, 0, 0, 1);
    run_fill(8, 2, 3, 23'h002000, 100, 0, 0, 0, 0, 5, 1, 0);
    run_fill(3, 2, 2, 23'h003000, 100, 0, 0, 0, 0, 0, 0, 1);
    run_fill(5, 2, 2, 23'h004000, 100, 0, 0, 0, 0, 6, 2, 0);
    run_fill(1, 2, 0, 23'h005000, 100, 0, 0, 0, 0, 0, 0, 1);
    run_fill(0, 0, 0, 23'h006000, 100, 0, 0, 0, 0, 0, 0, 1);
    run_fill(2, 1, 0, 23'h7FFFFF, 100, 0, 0, 0, 0, 0, 0, 1);

    for (int r = 0; r < 12; r++) begin
      run_fill($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 6),
               23'($urandom), $urandom_range(40, 100), $urandom_range(0, 30),
               0, 0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
